// File: rtl/operand_buf_pkg.sv
// rtl/operand_buf_pkg.sv - shared defaults, derived sizes and bank state type for the operand ping-pong buffer
package operand_buf_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_A_DIM  = 4;
  localparam int DEF_B_DIM  = 3;

  localparam int A_ELEMS = DEF_A_DIM * DEF_A_DIM;
  localparam int B_ELEMS = DEF_B_DIM * DEF_B_DIM;
  localparam int TOTAL   = A_ELEMS + B_ELEMS;
  localparam int CNT_W   = $clog2(TOTAL);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

endpackage

// File: rtl/operand_bank.sv
// rtl/operand_bank.sv - one operand bank: element storage, fill state and packed A/B views
module operand_bank
  import operand_buf_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int N_A     = A_ELEMS,
  parameter int N_B     = B_ELEMS,
  parameter int IDX_W   = CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_idx,
  input  logic [DATA_W-1:0]     i_data,
  input  logic                  i_last,
  input  logic                  i_discard,
  input  logic                  i_release,
  input  logic                  i_clear,
  output bank_state_t           o_state,
  output logic [N_A*DATA_W-1:0] o_a,
  output logic [N_B*DATA_W-1:0] o_b
);

  localparam int N_TOT = N_A + N_B;

  logic [DATA_W-1:0] r_mem [N_TOT];
  bank_state_t       r_state;

  // Fill state: release empties a full bank, a write fills it, frame_start drops a partial frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= EMPTY;
    end else if (i_release) begin
      r_state <= EMPTY;
    end else if (i_we) begin
      r_state <= i_last ? FULL : FILLING;
    end else if (i_discard) begin
      r_state <= EMPTY;
    end
  end

  // Element storage: one write port addressed by stream index, optional whole-bank clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_TOT; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < N_TOT; i++) begin
        if (i_clear) begin
          r_mem[i] <= '0;
        end else if (i_we && (i_idx == IDX_W'(i))) begin
          r_mem[i] <= i_data;
        end
      end
    end
  end

  // Pack storage into the A and B buses, element 0 in the LSBs
  always_comb begin
    o_a = '0;
    o_b = '0;
    for (int i = 0; i < N_A; i++) o_a[i*DATA_W +: DATA_W] = r_mem[i];
    for (int j = 0; j < N_B; j++) o_b[j*DATA_W +: DATA_W] = r_mem[N_A + j];
  end

  assign o_state = r_state;

endmodule

// File: rtl/operand_pingpong_buffer.sv
// rtl/operand_pingpong_buffer.sv - two-bank operand buffer: serial A/B load, parallel presentation; OPERAND_BANK_CLEAR_EN zeroes a bank on release
module operand_pingpong_buffer
  import operand_buf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int A_DIM  = DEF_A_DIM,
  parameter int B_DIM  = DEF_B_DIM
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            frame_start,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_W-1:0]               in_data,
  output logic                            out_valid,
  input  logic                            out_release,
  output logic [A_DIM*A_DIM*DATA_W-1:0]   out_a,
  output logic [B_DIM*B_DIM*DATA_W-1:0]   out_b,
  output logic                            wr_bank_o,
  output logic                            rd_bank_o
);

  localparam int N_A   = A_DIM * A_DIM;
  localparam int N_B   = B_DIM * B_DIM;
  localparam int N_TOT = N_A + N_B;
  localparam int IDX_W = $clog2(N_TOT);

  logic [IDX_W-1:0] r_cnt;
  logic             r_wr_bank;
  logic             r_rd_bank;
  logic             r_rst_done;

  bank_state_t             w_state [2];
  logic [N_A*DATA_W-1:0]   w_a     [2];
  logic [N_B*DATA_W-1:0]   w_b     [2];
  logic [1:0]              w_we;
  logic [1:0]              w_discard;
  logic [1:0]              w_rel;
  logic [1:0]              w_clear;

  logic             w_wr_full;
  logic             w_accept;
  logic             w_fs;
  logic [IDX_W-1:0] w_idx;
  logic             w_last;
  logic             w_release;

  // A full write bank means both banks are occupied; a completed frame is never discarded
  assign w_wr_full = (w_state[r_wr_bank] == FULL);
  assign in_ready  = r_rst_done & ~w_wr_full;
  assign w_accept  = in_valid & in_ready;
  assign w_fs      = frame_start & ~w_wr_full;
  assign w_idx     = w_fs ? '0 : r_cnt;
  assign w_last    = (w_idx == IDX_W'(N_TOT - 1));

  assign out_valid = (w_state[r_rd_bank] == FULL);
  assign w_release = out_release & out_valid;

  // Element counter and write pointer: wrap on the last element flips to the other bank
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_wr_bank <= 1'b0;
    end else if (w_accept) begin
      if (w_last) begin
        r_cnt     <= '0;
        r_wr_bank <= ~r_wr_bank;
      end else begin
        r_cnt <= w_idx + 1'b1;
      end
    end else if (w_fs) begin
      r_cnt <= '0;
    end
  end

  // Read pointer advances only on a release of a full bank
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_bank <= 1'b0;
    end else if (w_release) begin
      r_rd_bank <= ~r_rd_bank;
    end
  end

  // Hold off in_ready for the first cycle after reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    assign w_we[g]      = w_accept  & (r_wr_bank == 1'(g));
    assign w_discard[g] = w_fs      & (r_wr_bank == 1'(g));
    assign w_rel[g]     = w_release & (r_rd_bank == 1'(g));
`ifdef OPERAND_BANK_CLEAR_EN
    assign w_clear[g]   = w_rel[g];
`else
    assign w_clear[g]   = 1'b0;
`endif

    operand_bank #(
      .DATA_W (DATA_W),
      .N_A    (N_A),
      .N_B    (N_B),
      .IDX_W  (IDX_W)
    ) u_bank (
      .clk       (clk),
      .rst       (rst),
      .i_we      (w_we[g]),
      .i_idx     (w_idx),
      .i_data    (in_data),
      .i_last    (w_last),
      .i_discard (w_discard[g]),
      .i_release (w_rel[g]),
      .i_clear   (w_clear[g]),
      .o_state   (w_state[g]),
      .o_a       (w_a[g]),
      .o_b       (w_b[g])
    );
  end

  assign out_a     = w_a[r_rd_bank];
  assign out_b     = w_b[r_rd_bank];
  assign wr_bank_o = r_wr_bank;
  assign rd_bank_o = r_rd_bank;

endmodule

// File: tb/tb_operand_pingpong_buffer.sv
// tb/tb_operand_pingpong_buffer.sv - directed self-checking bench for operand_pingpong_buffer
module tb_operand_pingpong_buffer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         frame_start = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_data = 8'd0;
  logic         out_valid;
  logic         out_release = 1'b0;
  logic [127:0] out_a;
  logic [71:0]  out_b;
  logic         wr_bank_o;
  logic         rd_bank_o;

  logic [127:0] exp_a;
  logic [71:0]  exp_b;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  operand_pingpong_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_release (out_release),
    .out_a       (out_a),
    .out_b       (out_b),
    .wr_bank_o   (wr_bank_o),
    .rd_bank_o   (rd_bank_o)
  );

  task automatic set_exp(input int base);
    for (int i = 0; i < 16; i++) exp_a[i*8 +: 8] = 8'(base + i);
    for (int j = 0; j < 9; j++)  exp_b[j*8 +: 8] = 8'(base + 16 + j);
  endtask

  task automatic send_beat(input int d, input logic fs, input logic rel);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'(d); frame_start = fs; out_release = rel;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL send_beat_timeout got in_ready=%0b exp 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; frame_start = 1'b0; out_release = 1'b0;
  endtask

  task automatic send_frame(input int base, input int n);
    for (int i = 0; i < n; i++) send_beat(base + i, 1'b0, 1'b0);
  endtask

  task automatic pulse_release();
    @(negedge clk); out_release = 1'b1;
    @(posedge clk); #1; out_release = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %0b exp 0", out_valid); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready got %0b exp 0", in_ready); end
    tests++; if (out_a !== 128'd0) begin fails++; $display("FAIL rst_out_a got %0h exp 0", out_a); end
    tests++; if (out_b !== 72'd0) begin fails++; $display("FAIL rst_out_b got %0h exp 0", out_b); end
    tests++; if ({wr_bank_o, rd_bank_o} !== 2'b00) begin fails++; $display("FAIL rst_banks got %0b exp 00", {wr_bank_o, rd_bank_o}); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_ready_after got %0b exp 1", in_ready); end
  endtask

  task automatic test_single_frame();
    send_frame(1, 24);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL sf_valid_early got %0b exp 0", out_valid); end
    send_beat(25, 1'b0, 1'b0);
    set_exp(1);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL sf_valid got %0b exp 1", out_valid); end
    tests++; if (out_a[7:0] !== 8'd1) begin fails++; $display("FAIL sf_a0 got %0d exp 1", out_a[7:0]); end
    tests++; if (out_a[127:120] !== 8'd16) begin fails++; $display("FAIL sf_a15 got %0d exp 16", out_a[127:120]); end
    tests++; if (out_b[7:0] !== 8'd17) begin fails++; $display("FAIL sf_b0 got %0d exp 17", out_b[7:0]); end
    tests++; if (out_b[71:64] !== 8'd25) begin fails++; $display("FAIL sf_b8 got %0d exp 25", out_b[71:64]); end
    tests++; if (out_a !== exp_a || out_b !== exp_b) begin fails++; $display("FAIL sf_vec got %0h/%0h exp %0h/%0h", out_a, out_b, exp_a, exp_b); end
    tests++; if ({wr_bank_o, rd_bank_o} !== 2'b10) begin fails++; $display("FAIL sf_banks got %0b exp 10", {wr_bank_o, rd_bank_o}); end
  endtask

  task automatic test_two_frames();
    send_frame(101, 25);
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL tf_backpressure got %0b exp 0", in_ready); end
    tests++; if (out_a[7:0] !== 8'd1) begin fails++; $display("FAIL tf_a0_frame1 got %0d exp 1", out_a[7:0]); end
    tests++; if ({out_valid, wr_bank_o, rd_bank_o} !== 3'b100) begin fails++; $display("FAIL tf_state got %0b exp 100", {out_valid, wr_bank_o, rd_bank_o}); end
  endtask

  task automatic test_release();
    pulse_release();
    set_exp(101);
    tests++; if ({out_valid, rd_bank_o, in_ready} !== 3'b111) begin fails++; $display("FAIL rel_state got %0b exp 111", {out_valid, rd_bank_o, in_ready}); end
    tests++; if (out_a !== exp_a || out_b !== exp_b) begin fails++; $display("FAIL rel_vec got %0h/%0h exp %0h/%0h", out_a, out_b, exp_a, exp_b); end
    pulse_release();
    tests++; if ({out_valid, rd_bank_o, wr_bank_o} !== 3'b000) begin fails++; $display("FAIL rel2_state got %0b exp 000", {out_valid, rd_bank_o, wr_bank_o}); end
`ifdef OPERAND_BANK_CLEAR_EN
    tests++; if (out_a !== 128'd0 || out_b !== 72'd0) begin fails++; $display("FAIL rel2_cleared got %0h/%0h exp 0/0", out_a, out_b); end
`else
    set_exp(1);
    tests++; if (out_a !== exp_a || out_b !== exp_b) begin fails++; $display("FAIL rel2_stale got %0h/%0h exp %0h/%0h", out_a, out_b, exp_a, exp_b); end
`endif
  endtask

  task automatic test_frame_start();
    send_frame(150, 10);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fs_partial_valid got %0b exp 0", out_valid); end
    @(negedge clk); frame_start = 1'b1;
    @(posedge clk); #1; frame_start = 1'b0;
    send_frame(201, 25);
    set_exp(201);
    tests++; if ({out_valid, rd_bank_o, wr_bank_o} !== 3'b101) begin fails++; $display("FAIL fs_state got %0b exp 101", {out_valid, rd_bank_o, wr_bank_o}); end
    tests++; if (out_a !== exp_a || out_b !== exp_b) begin fails++; $display("FAIL fs_vec got %0h/%0h exp %0h/%0h", out_a, out_b, exp_a, exp_b); end
    pulse_release();
    send_frame(1, 5);
    send_beat(230, 1'b1, 1'b0);
    send_frame(231, 24);
    set_exp(230);
    tests++; if ({out_valid, rd_bank_o, wr_bank_o} !== 3'b110) begin fails++; $display("FAIL fs_beat_state got %0b exp 110", {out_valid, rd_bank_o, wr_bank_o}); end
    tests++; if (out_a !== exp_a || out_b !== exp_b) begin fails++; $display("FAIL fs_beat_vec got %0h/%0h exp %0h/%0h", out_a, out_b, exp_a, exp_b); end
  endtask

  task automatic test_async_reset();
    send_frame(40, 12);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    tests++; if ({out_valid, rd_bank_o, wr_bank_o, in_ready} !== 4'b0000) begin fails++; $display("FAIL ar_state got %0b exp 0000", {out_valid, rd_bank_o, wr_bank_o, in_ready}); end
    tests++; if (out_a !== 128'd0 || out_b !== 72'd0) begin fails++; $display("FAIL ar_data got %0h/%0h exp 0/0", out_a, out_b); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL ar_ready got %0b exp 1", in_ready); end
    send_frame(70, 25);
    set_exp(70);
    tests++; if ({out_valid, rd_bank_o, wr_bank_o} !== 3'b101) begin fails++; $display("FAIL ar_frame_state got %0b exp 101", {out_valid, rd_bank_o, wr_bank_o}); end
    tests++; if (out_a !== exp_a || out_b !== exp_b) begin fails++; $display("FAIL ar_frame_vec got %0h/%0h exp %0h/%0h", out_a, out_b, exp_a, exp_b); end
  endtask

  task automatic test_release_edge();
    pulse_release();
    tests++; if ({out_valid, rd_bank_o} !== 2'b01) begin fails++; $display("FAIL re_drain got %0b exp 01", {out_valid, rd_bank_o}); end
    pulse_release();
    tests++; if ({out_valid, rd_bank_o, wr_bank_o} !== 3'b011) begin fails++; $display("FAIL re_ignored got %0b exp 011", {out_valid, rd_bank_o, wr_bank_o}); end
    send_frame(120, 25);
    tests++; if ({out_valid, rd_bank_o, wr_bank_o} !== 3'b110) begin fails++; $display("FAIL re_fill1 got %0b exp 110", {out_valid, rd_bank_o, wr_bank_o}); end
    tests++; if (out_a[7:0] !== 8'd120) begin fails++; $display("FAIL re_fill1_a0 got %0d exp 120", out_a[7:0]); end
    send_frame(160, 24);
    send_beat(184, 1'b0, 1'b1);
    set_exp(160);
    tests++; if ({out_valid, rd_bank_o, wr_bank_o, in_ready} !== 4'b1011) begin fails++; $display("FAIL re_coincident got %0b exp 1011", {out_valid, rd_bank_o, wr_bank_o, in_ready}); end
    tests++; if (out_a !== exp_a || out_b !== exp_b) begin fails++; $display("FAIL re_coincident_vec got %0h/%0h exp %0h/%0h", out_a, out_b, exp_a, exp_b); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_two_frames();
    test_release();
    test_frame_start();
    test_async_reset();
    test_release_edge();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/operand_pingpong_buffer.md
Name: operand_pingpong_buffer

Overview:
- Parametrised successor to the flat A/B operand register block feeding the systolic array.
- Accepts matrix A (A_DIM x A_DIM) and filter B (B_DIM x B_DIM) as a serial element stream with valid/ready handshake.
- Stores operands in two ping-pong banks, so one frame loads while the array consumes the other.
- Presents the active bank as packed parallel buses with a valid/release handshake to the array controller.

Parameters:
- DATA_W, 8, element width in bits.
- A_DIM, 4, matrix A dimension; A holds A_DIM*A_DIM elements.
- B_DIM, 3, filter B dimension; B holds B_DIM*B_DIM elements.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- frame_start  in  1  pulse; resynchronises the write element counter to 0 and discards any partial frame in the write bank.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  buffer can accept an element this cycle.
- in_data  in  DATA_W  element. Order: A row-major (A11..A_NN), then B row-major (B11..B_MM).
- out_valid  out  1  read bank holds a complete frame.
- out_release  in  1  pulse; consumer is finished with the read bank.
- out_a  out  A_DIM*A_DIM*DATA_W  packed A. Element (r,c) sits at slice index r*A_DIM+c; index 0 is in the LSBs.
- out_b  out  B_DIM*B_DIM*DATA_W  packed B, same packing rule.
- wr_bank_o  out  1  index of the bank currently being written.
- rd_bank_o  out  1  index of the bank currently presented.

Behaviour:
- Reset (rst=0, async):
  - All storage is 0; out_a=0, out_b=0, out_valid=0.
  - Both banks EMPTY; wr_bank=rd_bank=0; element counter=0.
  - in_ready=1 one cycle after rst deasserts.
- Bank states: EMPTY -> FILLING -> FULL -> EMPTY.
  - EMPTY->FILLING on the first accepted beat.
  - FILLING->FULL on acceptance of element TOTAL-1, where TOTAL=A_DIM^2+B_DIM^2 (25 by default).
  - FULL->EMPTY on out_release while that bank is the read bank and out_valid=1.
- Accept rule:
  - A beat is accepted when in_valid & in_ready.
  - Element index k<A_DIM^2 writes A[k]; otherwise it writes B[k-A_DIM^2].
  - The counter increments per accepted beat and wraps to 0 after TOTAL-1.
  - On wrap, wr_bank toggles in the same edge.
- in_ready is 1 when bank[wr_bank] is EMPTY or FILLING, and 0 when it is FULL (backpressure: both banks occupied).
- out_valid is 1 when bank[rd_bank] is FULL. out_a/out_b always reflect bank[rd_bank] storage. Outputs are register-driven, with no combinational path from in_data.
- Latency: final beat accepted at edge t -> out_valid=1 after edge t, provided that bank is the read bank.
- out_release with out_valid=1: the bank goes EMPTY and rd_bank toggles at that edge. out_release with out_valid=0 is ignored.
- Simultaneous last-beat acceptance and release:
  - Both take effect in the same edge.
  - If the released bank is the next write bank, in_ready=1 the following cycle.
- frame_start:
  - Counter is forced to 0 and bank[wr_bank] goes EMPTY; its stale data is retained until overwritten.
  - frame_start together with an accepted beat: that beat is written as element 0 and the counter becomes 1.
  - frame_start while bank[wr_bank] is FULL: ignored, because a completed frame is never discarded.
- Reset mid-frame: all state is cleared asynchronously, and partial or complete frames are lost.

Optional Feature:
- Macro: OPERAND_BANK_CLEAR_EN.
- Defined: on an accepted release, the released bank's storage is zeroed in the same edge. out_a/out_b therefore read 0 while out_valid=0 after a drain.
- Undefined: the released bank retains its data until overwritten, and out_a/out_b show stale contents when out_valid=0.

Decomposition:
- Package operand_buf_pkg holds:
  - default DATA_W/A_DIM/B_DIM;
  - derived localparams A_ELEMS, B_ELEMS, TOTAL, CNT_W=$clog2(TOTAL);
  - the bank_state enum (EMPTY, FILLING, FULL).
- Sub-module operand_bank: one bank's storage, state register, write port (index, data, we), clear input and packed outputs. It is instantiated twice.
- The top level owns the counter, bank pointers, handshake and output mux.

Test Plan:
- Reset then stream 1..25 with in_valid held -> out_valid rises the cycle after beat 25; out_a slice0=1, slice15=16; out_b slice0=17, slice8=25; rd_bank_o=0.
- Stream two frames (1..25, 101..125) with no release -> second frame fills bank1; in_ready drops to 0 after beat 50; out_a still shows frame 1.
- Release frame 1 -> rd_bank_o=1 and out_a slice0=101 next cycle; in_ready=1. With OPERAND_BANK_CLEAR_EN defined, bank0 reads all 0.
- Send 10 beats, pulse frame_start, then stream 201..225 -> out_a slice0=201; no element of the partial frame appears.
- Assert rst=0 mid-frame (beat 12, asynchronous to clk) -> outputs 0 immediately; after release of reset, a fresh 25-beat frame loads correctly into bank0.
- Release pulsed with out_valid=0, and release coincident with the final beat of the other bank -> the first is ignored; the second drives both state updates in one edge and out_valid stays 1.
